// File: rtl/glitch_sequencer.sv
// glitch_sequencer: delay / window / gap timing controller for glitch_injector.
// Rev 1.0 - initial release.
`default_nettype none

module glitch_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [7:0]       count,
  output logic             enable,
  output logic             enable_specific,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [7:0]       glitch_idx
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    GLITCH = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] width_q;   // holds the effective width, never 0
  logic [CNT_W-1:0] gap_q;
  logic [7:0]       remaining;
  logic             mode_q;
  logic [CNT_W-1:0] weff_in;

  assign weff_in = (width == '0) ? CNT_ONE : width;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      width_q         <= '0;
      gap_q           <= '0;
      remaining       <= '0;
      mode_q          <= 1'b0;
      enable          <= 1'b0;
      enable_specific <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      glitch_idx      <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state != IDLE && abort) begin
        state           <= IDLE;
        cnt             <= '0;
        enable          <= 1'b0;
        enable_specific <= 1'b0;
        busy            <= 1'b0;
        aborted         <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              glitch_idx <= '0;
              mode_q     <= mode;
              width_q    <= weff_in;
              gap_q      <= gap;
              remaining  <= count;
              if (count == 8'd0) begin
                done <= 1'b1;
              end else if (delay == '0) begin
                state           <= GLITCH;
                cnt             <= weff_in - CNT_ONE;
                busy            <= 1'b1;
                enable          <= ~mode;
                enable_specific <= mode;
              end else begin
                state <= DELAY;
                cnt   <= delay - CNT_ONE;
                busy  <= 1'b1;
              end
            end
          end

          DELAY: begin
            if (cnt == '0) begin
              state           <= GLITCH;
              cnt             <= width_q - CNT_ONE;
              enable          <= ~mode_q;
              enable_specific <= mode_q;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end

          GLITCH: begin
            if (cnt == '0) begin
              remaining <= remaining - 8'd1;
              if (remaining == 8'd1) begin
                state           <= IDLE;
                busy            <= 1'b0;
                enable          <= 1'b0;
                enable_specific <= 1'b0;
                done            <= 1'b1;
              end else if (gap_q == '0) begin
                // back-to-back windows: enables stay high across the boundary
                cnt        <= width_q - CNT_ONE;
                glitch_idx <= glitch_idx + 8'd1;
              end else begin
                state           <= GAP;
                cnt             <= gap_q - CNT_ONE;
                enable          <= 1'b0;
                enable_specific <= 1'b0;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end

          GAP: begin
            if (cnt == '0) begin
              state           <= GLITCH;
              cnt             <= width_q - CNT_ONE;
              glitch_idx      <= glitch_idx + 8'd1;
              enable          <= ~mode_q;
              enable_specific <= mode_q;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: cycle-level arithmetic model plus directed scenarios.
`default_nettype none

module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] delay = '0;
  logic [15:0] width = '0;
  logic [15:0] gap = '0;
  logic [7:0]  count = '0;
  logic        enable, enable_specific, busy, done, aborted;
  logic [7:0]  glitch_idx;

  int n_cmp = 0;
  int n_bad = 0;

  glitch_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .delay(delay), .width(width), .gap(gap), .count(count),
    .enable(enable), .enable_specific(enable_specific), .busy(busy),
    .done(done), .aborted(aborted), .glitch_idx(glitch_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: campaign described by its parameters and the cycle number within it.
  bit m_run = 0;
  bit m_abt = 0;
  bit m_mode = 0;
  int m_c = 0;
  int m_D = 0, m_W = 1, m_G = 0, m_N = 0;
  int m_hold = 0;

  function automatic int m_T();
    return (m_N == 0) ? 0 : m_D + m_N * m_W + (m_N - 1) * m_G;
  endfunction

  function automatic bit m_busy();
    return m_run && (m_c < m_T());
  endfunction

  function automatic bit m_done();
    return m_run && (m_c == m_T());
  endfunction

  function automatic bit m_win();
    return m_busy() && (m_c >= m_D) && (((m_c - m_D) % (m_W + m_G)) < m_W);
  endfunction

  function automatic int m_idx();
    int k;
    if (!m_run) return m_hold;
    if (m_N == 0 || m_c < m_D) return 0;
    k = (m_c - m_D) / (m_W + m_G);
    return (k > m_N - 1) ? m_N - 1 : k;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run  <= 0;
      m_abt  <= 0;
      m_hold <= 0;
      m_c    <= 0;
    end else begin
      m_abt <= 0;
      if (m_busy()) begin
        if (abort) begin
          m_run  <= 0;
          m_abt  <= 1;
          m_hold <= m_idx();
        end else begin
          m_c <= m_c + 1;
        end
      end else begin
        if (m_run) m_hold <= m_idx();
        m_run <= 0;
        if (start && !abort) begin
          m_run  <= 1;
          m_c    <= 0;
          m_D    <= int'(delay);
          m_W    <= (width == 16'd0) ? 1 : int'(width);
          m_G    <= int'(gap);
          m_N    <= int'(count);
          m_mode <= mode;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("enable", {31'd0, enable}, {31'd0, m_win() & ~m_mode});
    check("enable_specific", {31'd0, enable_specific}, {31'd0, m_win() & m_mode});
    check("busy", {31'd0, busy}, {31'd0, m_busy()});
    check("done", {31'd0, done}, {31'd0, m_done()});
    check("aborted", {31'd0, aborted}, {31'd0, m_abt});
    check("glitch_idx", {24'd0, glitch_idx}, m_idx());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 of the new campaign.
  task automatic launch(input int d, input int w, input int g, input int n, input bit md);
    delay = 16'(d);
    width = 16'(w);
    gap   = 16'(g);
    count = 8'(n);
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_enable", {31'd0, enable}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_idx", {24'd0, glitch_idx}, 0);
    reset = 1'b0;
    tick();

    // windows at 3-4, 9-10, 15-16; done at 17
    launch(3, 2, 4, 3, 1'b0);
    for (int c = 0; c <= 17; c++) begin
      check("t1_enable", {31'd0, enable},
            {31'd0, (c == 3 || c == 4 || c == 9 || c == 10 || c == 15 || c == 16)});
      check("t1_done", {31'd0, done}, {31'd0, (c == 17)});
      if (c == 4)  check("t1_idx0", {24'd0, glitch_idx}, 0);
      if (c == 10) check("t1_idx1", {24'd0, glitch_idx}, 1);
      if (c == 16) check("t1_idx2", {24'd0, glitch_idx}, 2);
      tick();
    end
    tick();

    // specific mode, zero width/gap/delay: enable_specific 0-3, done at 4
    launch(0, 0, 0, 4, 1'b1);
    for (int c = 0; c <= 4; c++) begin
      check("t2_en_spec", {31'd0, enable_specific}, {31'd0, (c <= 3)});
      check("t2_done", {31'd0, done}, {31'd0, (c == 4)});
      if (c == 4) check("t2_idx", {24'd0, glitch_idx}, 3);
      tick();
    end

    // count 0: immediate done, never busy
    launch(2, 2, 2, 0, 1'b0);
    check("t3_done", {31'd0, done}, 1);
    check("t3_busy", {31'd0, busy}, 0);
    tick();
    tick();

    // abort in cycle 7, restart in cycle 8
    launch(5, 10, 0, 1, 1'b0);
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_aborted", {31'd0, aborted}, 1);
    check("t4_enable", {31'd0, enable}, 0);
    check("t4_busy", {31'd0, busy}, 0);
    launch(0, 1, 0, 1, 1'b0);
    check("t4_restart_en", {31'd0, enable}, 1);
    tick();
    check("t4_restart_done", {31'd0, done}, 1);
    tick();

    // start + input changes mid-campaign are ignored: windows 2-4, 6-8, done 9
    launch(2, 3, 1, 2, 1'b0);
    tick();
    start = 1'b1;
    width = 16'd7;
    delay = 16'd0;
    mode  = 1'b1;
    count = 8'd9;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      check("t5_enable", {31'd0, enable},
            {31'd0, (c >= 2 && c <= 4) || (c >= 6 && c <= 8)});
      check("t5_done", {31'd0, done}, {31'd0, (c == 9)});
      if (c < 9) tick();
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t5_sa_busy", {31'd0, busy}, 0);
    check("t5_sa_aborted", {31'd0, aborted}, 0);
    tick();

    // asynchronous reset during GLITCH
    launch(0, 1, 0, 3, 1'b0);
    tick();
    check("t6_pre_idx", {24'd0, glitch_idx}, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_enable", {31'd0, enable}, 0);
    check("t6_rst_busy", {31'd0, busy}, 0);
    check("t6_rst_idx", {24'd0, glitch_idx}, 0);
    tick();
    reset = 1'b0;
    tick();
    launch(1, 1, 0, 1, 1'b0);
    check("t6_c0_enable", {31'd0, enable}, 0);
    tick();
    check("t6_c1_enable", {31'd0, enable}, 1);
    tick();
    check("t6_c2_done", {31'd0, done}, 1);
    tick();

    // maximum delay without wrap
    launch(65535, 1, 0, 1, 1'b0);
    repeat (65534) tick();
    check("t7_pre_enable", {31'd0, enable}, 0);
    tick();
    check("t7_enable", {31'd0, enable}, 1);
    tick();
    check("t7_done", {31'd0, done}, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/glitch_sequencer.md
# glitch_sequencer

Timing controller that drives the `enable` / `enable_specific` inputs of `glitch_injector` for the dual-core glitch-protection tests. After a start pulse it waits a programmable delay, then fires a programmable number of glitch windows of programmable width, separated by a programmable gap. Each window selects either random or fixed-pattern mode. It gives fault campaigns cycle-exact, repeatable injection points relative to a trigger (e.g. a core event).

## Interface
- `CNT_W`, 16: width of `delay`, `width` and `gap`, and of the internal cycle counter.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  terminates any campaign in progress.
- `mode`  in  1  0 = random glitch (drive `enable`), 1 = specific pattern (drive `enable_specific`).
- `delay`  in  CNT_W  cycles from start acceptance to the first glitch.
- `width`  in  CNT_W  cycles per glitch window; 0 is treated as 1.
- `gap`  in  CNT_W  cycles between windows; 0 means the windows are back-to-back.
- `count`  in  8  number of glitch windows; 0 means no glitch.
- `enable`  out  1  to injector `enable`.
- `enable_specific`  out  1  to injector `enable_specific`.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `aborted`  out  1  one-cycle pulse when a campaign is aborted.
- `glitch_idx`  out  8  index of the current or last window (0-based).

## Operation
- States: IDLE, DELAY, GLITCH, GAP. All outputs are registered.
- Reset values: every output is 0, state is IDLE, counter is 0.
- `mode`, `delay`, `width`, `gap` and `count` are latched on start acceptance. Input changes afterwards have no effect.
- IDLE, with `start` = 1, `abort` = 0:
  - `glitch_idx` is cleared.
  - If `count` = 0: no state change, `done` pulses next cycle, `busy` stays 0.
  - Else if `delay` = 0: go to GLITCH with cnt = weff-1, where weff = max(`width`, 1).
  - Else: go to DELAY with cnt = `delay`-1.
- DELAY: decrement cnt. At cnt = 0, go to GLITCH with cnt = weff-1.
- GLITCH: decrement cnt. At cnt = 0:
  - If this is the last window (remaining = 1): go to IDLE and set `done` = 1 for one cycle.
  - Else if `gap` = 0: stay in GLITCH, reload cnt = weff-1, `glitch_idx`++.
  - Else: go to GAP with cnt = `gap`-1.
- GAP: decrement cnt. At cnt = 0, go to GLITCH with cnt = weff-1 and `glitch_idx`++.
- The remaining-window counter is loaded with `count` and decrements at the end of each window.
- `enable` = (state = GLITCH) & ~mode_q. `enable_specific` = (state = GLITCH) & mode_q. The two are never high together.
- `abort` in any non-IDLE state: go to IDLE at the next edge and pulse `aborted`; `done` is not pulsed. `abort` in IDLE has no effect and takes priority over a simultaneous `start`.
- `start` while `busy` is ignored.
- `glitch_idx` holds its value after `done` or `aborted` until the next accepted start.
- `reset` mid-campaign: outputs drop to 0 immediately (asynchronous); no `done` or `aborted` pulse.

## Timing
- Number cycles from 0 = the first cycle after the edge that samples `start`.
- `busy` is high in cycles 0 .. T-1, with T = D + N·weff + (N-1)·gap.
- Window k (0-based) occupies cycles D + k·(weff+gap) .. D + k·(weff+gap) + weff-1.
- `done` is high in cycle T, with `busy` = 0 in that cycle. A new `start` is accepted in cycle T.
- With `gap` = 0, `enable` stays continuously high for N·weff cycles.
- Abort sampled at an edge: `enable`, `enable_specific` and `busy` are 0 and `aborted` = 1 in the following cycle.
- Counter arithmetic is unsigned CNT_W-bit. A maximum `delay` of 2^CNT_W-1 is supported with no wrap.

## Test plan
- `delay`=3, `width`=2, `gap`=4, `count`=3, `mode`=0 -> `enable` high in cycles 3-4, 9-10 and 15-16; `enable_specific` stays 0; `glitch_idx` goes 0, 1, 2; `done` in cycle 17.
- `delay`=0, `width`=0, `gap`=0, `count`=4, `mode`=1 -> `enable_specific` high in cycles 0-3; `glitch_idx` ends at 3; `done` in cycle 4.
- `count`=0 with `start` -> `done` in cycle 0, `busy` and `enable` never assert.
- `delay`=5, `width`=10, `count`=1; `abort` during cycle 7 -> `enable` 0 and `aborted`=1 in cycle 8; no `done` pulse; `start` in cycle 8 is accepted.
- During a campaign, pulse `start` and change `width` -> no effect on timing. `start` and `abort` together in IDLE -> nothing happens.
- Assert `reset` during GLITCH -> `enable`, `busy` and `glitch_idx` go to 0 without waiting for a clock edge. After release, a normal campaign (`delay`=1, `width`=1, `count`=1) -> `enable` high in cycle 1, `done` in cycle 2.
